posit_encoder: RTL
==================

// Module: posit_encoder
// PURPOSE
//   Packs decoded posit fields (sign, regime k, exponent, fraction) into an N-bit posit word.
//   It is the output end of the ALU datapath: decoder -> comparator/adder/multiplier -> posit_encoder.
//   2-stage pipeline with valid/ready on both sides.
//   Performs regime run-length construction, round-to-nearest-even, saturation and two's complement.
// PARAMETERS
//   N      16  posit word width (>= 8)
//   ES     2'd1 -> 1  exponent field width in bits
//   W_REG  6   signed regime input width; k range -(2^(W_REG-1)) .. 2^(W_REG-1)-1
//   W_EXP  2   signed exponent input width; only value range [0, 2^ES-1] is legal
//   W_MAN  16  fraction input width, MSB-aligned, hidden bit excluded
// PORTS
//   clk          in   1      clock, all state on rising edge
//   rst          in   1      synchronous reset, active-high
//   in_valid     in   1      input fields valid
//   in_ready     out  1      encoder can accept this cycle
//   in_sign      in   1      sign_t: 1 = negative
//   in_zero      in   1      value is exact zero (other fields ignored)
//   in_nar       in   1      value is NaR (priority over in_zero)
//   in_regime    in   W_REG  signed regime k
//   in_exponent  in   W_EXP  exponent; low ES bits used
//   in_mantissa  in   W_MAN  fraction bits after the hidden 1
//   out_valid    out  1      out_posit valid
//   out_ready    in   1      downstream accepts
//   out_posit    out  N      encoded posit
// BEHAVIOUR
//   Reset: out_valid=0, out_posit=0, both stage-valid flags=0; in_ready=0 while rst high.
//   Reset mid-operation: in-flight data is discarded. No output appears for it.
//   Handshake:
//     - adv2 = !s2_valid | out_ready
//     - adv1 = !s1_valid | adv2
//     - in_ready = adv1 & !rst (combinational)
//   Transfers:
//     - An input transfer occurs when in_valid & in_ready.
//     - An output transfer occurs when out_valid & out_ready.
//   Latency: exactly 2 cycles from input transfer to out_valid with no stall. Throughput 1/cycle.
//   Stall: while out_valid & !out_ready, out_posit and out_valid hold stable. s1 holds if occupied.
//   Stage 1 (regime/concat), for magnitude only:
//     - k>=0: k+1 ones then a 0.
//     - k<0: -k zeros then a 1.
//     - Then ES exponent bits, then in_mantissa.
//     - Form the top N-1 bits plus guard bit G and sticky S (OR of all remaining bits).
//     - Saturate: k >= N-2 -> maxpos magnitude 0111..1; k <= -(N-1) -> minpos magnitude 000..01.
//     - Saturated values skip rounding.
//     - Regime or exponent bits truncated by the word end count in G/S like fraction bits.
//   Stage 2 (round/sign):
//     - RNE: round up iff G & (S | lsb).
//     - Magnitude never rounds past maxpos (clamp 0x7FFF for N=16).
//     - Magnitude never rounds to 0 (clamp to minpos).
//     - If in_sign, out_posit = two's complement of {1'b0, magnitude}.
//   Special cases:
//     - in_nar -> 1 followed by N-1 zeros (0x8000), regardless of sign.
//     - in_zero -> all zeros, with no -0.
//     - Specials bypass rounding but take the same 2-cycle latency.
//   Simultaneous output pop and input push: both occur in the same cycle, with no bubble.
//   Illegal in_exponent (negative or >= 2^ES): low ES bits used. Must be flagged by an assertion in sim.
// TESTING (N=16, ES=1, W_MAN=16)
//   1. Basic values:
//      - k=0, e=0, man=0 -> 0x4000.
//      - sign=1, same fields -> 0xC000.
//      - k=0, e=1 -> 0x5000.
//      - k=1, e=0 -> 0x6000.
//      - k=-1, e=1 -> 0x3000.
//   2. RNE ties:
//      - k=0, e=0, man=0x0008 (tie, even) -> 0x4000.
//      - man=0x0018 (tie, odd) -> 0x4002.
//      - man=0x0009 -> 0x4001.
//   3. Saturation:
//      - k=14 -> 0x7FFF; k=20 -> 0x7FFF; sign=1, k=20 -> 0x8001.
//      - k=-20 -> 0x0001; k=-15 -> 0x0001.
//      - k=13, e=1, man=0xFFFF -> 0x7FFF (no wrap).
//   4. Specials:
//      - in_nar=1 with in_zero=1 -> 0x8000.
//      - in_zero=1 with sign=1 -> 0x0000.
//   5. Back-pressure:
//      - Stream 0x4000, 0x5000, 0x6000; hold out_ready=0 for 3 cycles from cycle 2.
//      - Required: in_ready drops once both stages are full, out_posit holds 0x4000.
//      - Required: order preserved, no loss or duplication.
//      - Then full-rate push/pop gives 1 result per cycle.
//   6. Assert rst with 2 items in flight:
//      - Next cycle out_valid=0, out_posit=0, in_ready=0 while rst.
//      - After release the first new input appears exactly 2 cycles later.

Source files
------------

// File: rtl/posit_encoder.sv
// posit_encoder: packs decoded posit fields (sign, regime k, exponent, fraction) into an N-bit posit.
// Stage 1 builds the regime/exponent/fraction bit string; stage 2 rounds to nearest even and applies sign.
module posit_encoder #(
  parameter int N     = 16,
  parameter int ES    = 1,
  parameter int W_REG = 6,
  parameter int W_EXP = 2,
  parameter int W_MAN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic             in_zero,
  input  logic             in_nar,
  input  logic [W_REG-1:0] in_regime,
  input  logic [W_EXP-1:0] in_exponent,
  input  logic [W_MAN-1:0] in_mantissa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_posit
);

  localparam int T  = N - 1 + ES + W_MAN;
  localparam int KW = W_REG + 1;
  localparam logic [T-1:0]          ALL_ONES   = {T{1'b1}};
  localparam logic [T-1:0]          TOP_ONE    = {1'b1, {(T-1){1'b0}}};
  localparam logic signed [KW-1:0]  K_SAT_HI   = KW'(N - 2);
  localparam logic signed [KW-1:0]  K_SAT_LO   = KW'(-(N - 1));
  localparam logic [N-2:0]          MAXPOS_MAG = {(N-1){1'b1}};
  localparam logic [N-2:0]          MINPOS_MAG = {{(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0]          NAR_WORD   = {1'b1, {(N-1){1'b0}}};

  logic                 adv1_s, adv2_s, in_fire_s;
  logic                 s1_valid_q;
  logic                 s1_sign_q, s1_zero_q, s1_nar_q, s1_g_q, s1_s_q;
  logic [N-2:0]         s1_mag_q;
  logic                 s1_g_d, s1_s_d;
  logic [N-2:0]         s1_mag_d;
  logic                 out_valid_q;
  logic [N-1:0]         out_posit_q, out_posit_d;
  logic signed [KW-1:0] k_s;
  logic [KW-1:0]        run_len_s, reg_len_s;
  logic [T-1:0]         body_s, pattern_s, string_s;
  logic                 rnd_up_s;
  logic [N-1:0]         sum_s;
  logic [N-2:0]         mag_s;

  assign adv2_s    = ~out_valid_q | out_ready;
  assign adv1_s    = ~s1_valid_q | adv2_s;
  assign in_ready  = adv1_s & ~rst;
  assign in_fire_s = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;

  // Regime run, terminator, exponent and fraction, left-aligned in one T-bit string.
  always_comb begin
    k_s = {in_regime[W_REG-1], in_regime};
    if (k_s[KW-1]) begin
      run_len_s = -k_s;
      pattern_s = TOP_ONE >> run_len_s;
    end else begin
      run_len_s = k_s + KW'(1);
      pattern_s = ~(ALL_ONES >> run_len_s);
    end
    reg_len_s = run_len_s + KW'(1);
    body_s    = {in_exponent[ES-1:0], in_mantissa, {(N-1){1'b0}}};
    string_s  = pattern_s | (body_s >> reg_len_s);
  end

  // Saturated regimes produce maxpos/minpos directly with no guard/sticky, so rounding is skipped.
  always_comb begin
    if (k_s >= K_SAT_HI) begin
      s1_mag_d = MAXPOS_MAG;
      s1_g_d   = 1'b0;
      s1_s_d   = 1'b0;
    end else if (k_s <= K_SAT_LO) begin
      s1_mag_d = MINPOS_MAG;
      s1_g_d   = 1'b0;
      s1_s_d   = 1'b0;
    end else begin
      s1_mag_d = string_s[T-1 -: N-1];
      s1_g_d   = string_s[T-N];
      s1_s_d   = |string_s[T-N-1:0];
    end
  end

  // Stage 1 register: loads on an input transfer, holds while stage 2 is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_mag_q   <= {(N-1){1'b0}};
    end else if (adv1_s) begin
      s1_valid_q <= in_fire_s;
      if (in_fire_s) begin
        s1_sign_q <= in_sign;
        s1_zero_q <= in_zero;
        s1_nar_q  <= in_nar;
        s1_g_q    <= s1_g_d;
        s1_s_q    <= s1_s_d;
        s1_mag_q  <= s1_mag_d;
      end
    end
  end

  // Round to nearest even, clamp into [minpos, maxpos], then specials and sign.
  always_comb begin
    rnd_up_s = s1_g_q & (s1_s_q | s1_mag_q[0]);
    sum_s    = {1'b0, s1_mag_q} + {{(N-1){1'b0}}, rnd_up_s};
    if (sum_s[N-1]) begin
      mag_s = MAXPOS_MAG;
    end else if (sum_s[N-2:0] == {(N-1){1'b0}}) begin
      mag_s = MINPOS_MAG;
    end else begin
      mag_s = sum_s[N-2:0];
    end
    if (s1_nar_q) begin
      out_posit_d = NAR_WORD;
    end else if (s1_zero_q) begin
      out_posit_d = {N{1'b0}};
    end else if (s1_sign_q) begin
      out_posit_d = ~{1'b0, mag_s} + {{(N-1){1'b0}}, 1'b1};
    end else begin
      out_posit_d = {1'b0, mag_s};
    end
  end

  // Output register: holds word and valid while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_posit_q <= {N{1'b0}};
    end else if (adv2_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_posit_q <= out_posit_d;
      end
    end
  end

  // Exponents outside [0, 2^ES-1] are truncated to ES bits by the datapath.
  a_exp_legal: assert property (@(posedge clk) disable iff (rst)
      (in_valid && in_ready && !in_zero && !in_nar) |-> ((in_exponent >> ES) == {W_EXP{1'b0}}))
    else $error("posit_encoder: illegal in_exponent %0d", $signed(in_exponent));

endmodule
